// File: rtl/types_pkg.sv
// Shared type definitions for the RV32I cores.
// Holds the opcode, ALU operation and immediate-format encodings used by
// both cores, plus the state and mux-select encodings of the multicycle
// controller.
// No ports: this file is a package only.
package types_pkg;

   typedef enum logic [6:0] {
      OP_LOAD      = 7'b0000011,
      OP_I_ARITH   = 7'b0010011,
      OP_S         = 7'b0100011,
      OP_R         = 7'b0110011,
      OP_RV64_TYPE = 7'b0111011,
      OP_B         = 7'b1100011,
      OP_J         = 7'b1101111
   } opcode_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } aluop_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'd0,
      ALUOP_SUB   = 2'd1,
      ALUOP_FUNCT = 2'd2
   } aluop_type_e;

   typedef enum logic [1:0] {
      IMM_I = 2'd0,
      IMM_S = 2'd1,
      IMM_B = 2'd2,
      IMM_J = 2'd3
   } immsrc_e;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      TRAP     = 4'd11
   } mc_state_e;

   typedef enum logic [1:0] {
      SRCA_PC    = 2'd0,
      SRCA_OLDPC = 2'd1,
      SRCA_REGA  = 2'd2
   } alusrca_e;

   typedef enum logic [1:0] {
      SRCB_REGB = 2'd0,
      SRCB_IMM  = 2'd1,
      SRCB_FOUR = 2'd2
   } alusrcb_e;

   typedef enum logic [1:0] {
      RES_ALUOUT    = 2'd0,
      RES_DATA      = 2'd1,
      RES_ALURESULT = 2'd2
   } mc_resultsrc_e;

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU operation decoder for the multicycle controller.
// Turns the controller's requested operation class plus the instruction
// funct fields into a concrete ALU operation. Purely combinational.
// Ports:
//   alu_type    in  2  aluop_type_e requested by the FSM
//   funct3      in  3  IR[14:12]
//   funct7b5    in  1  IR[30]
//   op5         in  1  opcode bit 5 (1 = register form, 0 = immediate form)
//   alu_control out 4  aluop_e
module mc_alu_decoder
   import types_pkg::*;
(
   input  logic [1:0] alu_type,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [3:0] alu_control
);

   // funct3=000 is only a subtract for the register form; ADDI reuses
   // IR[30] as part of its immediate, so it must not select SUB.
   always_comb begin
      alu_control = ALU_ADD;
      case (alu_type)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         default: begin
            case (funct3)
               3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_control = ALU_SLL;
               3'b010:  alu_control = ALU_SLT;
               3'b011:  alu_control = ALU_SLTU;
               3'b100:  alu_control = ALU_XOR;
               3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_control = ALU_OR;
               default: alu_control = ALU_AND;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM that sequences the multicycle RV32I datapath (unified memory,
// IR, ALU, PC, register file). Drives every datapath strobe and mux select
// from the opcode/funct fields, the ALU zero flag and a memory ready
// handshake.
// Optional feature: define MC_ILLEGAL_TRAP_EN to add the illegal_instr
// output and a sticky TRAP state for illegal opcodes. Without it an illegal
// opcode is treated as a NOP.
// Ports:
//   clk, rst_n        clock (rising edge) and async active-low reset
//   op, funct3, funct7b5  instruction fields from IR
//   zero              ALU result == 0
//   mem_ready         memory completes the current access this cycle
//   mem_req, mem_write, adr_src       memory interface controls
//   ir_write, pc_write, reg_write     architectural state strobes
//   result_src, alu_src_a, alu_src_b, imm_src, alu_control  mux/ALU selects
//   illegal_instr     sticky illegal-opcode flag (MC_ILLEGAL_TRAP_EN only)
//   state_o           current state, for debug
module multicycle_controller
   import types_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic [3:0] alu_control,
`ifdef MC_ILLEGAL_TRAP_EN
   output logic       illegal_instr,
`endif
   output logic [3:0] state_o
);

   mc_state_e   state_q, state_d;
   logic [1:0]  alu_type;
   logic [3:0]  alu_dec;
   logic        legal_op;

   assign legal_op = (op == OP_LOAD) || (op == OP_S) || (op == OP_R) ||
                     (op == OP_I_ARITH) || (op == OP_B) || (op == OP_J);

   // Next-state logic. mem_ready only matters in the three memory states.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:    if (mem_ready) state_d = DECODE;
         DECODE: begin
            if (op == OP_LOAD || op == OP_S) state_d = MEMADR;
            else if (op == OP_R)             state_d = EXECR;
            else if (op == OP_I_ARITH)       state_d = EXECI;
            else if (op == OP_B)             state_d = BRANCH;
            else if (op == OP_J)             state_d = JAL;
            else begin
`ifdef MC_ILLEGAL_TRAP_EN
               state_d = TRAP;
`else
               state_d = FETCH;
`endif
            end
         end
         MEMADR:   state_d = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
         MEMREAD:  if (mem_ready) state_d = MEMWB;
         MEMWB:    state_d = FETCH;
         MEMWRITE: if (mem_ready) state_d = FETCH;
         EXECR:    state_d = ALUWB;
         EXECI:    state_d = ALUWB;
         ALUWB:    state_d = FETCH;
         BRANCH:   state_d = FETCH;
         JAL:      state_d = ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
         TRAP:     state_d = TRAP;
`endif
         default:  state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FETCH;
      else        state_q <= state_d;
   end

`ifdef MC_ILLEGAL_TRAP_EN
   logic illegal_instr_q, illegal_instr_d;

   // Set on the way out of DECODE with an illegal opcode; only reset clears it.
   always_comb begin
      illegal_instr_d = illegal_instr_q | ((state_q == DECODE) && !legal_op);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) illegal_instr_q <= 1'b0;
      else        illegal_instr_q <= illegal_instr_d;
   end

   assign illegal_instr = illegal_instr_q;
`else
   logic unused_legal;
   assign unused_legal = legal_op;
`endif

   // Operation class requested from the ALU decoder in each state.
   always_comb begin
      alu_type = ALUOP_ADD;
      case (state_q)
         EXECR, EXECI: alu_type = ALUOP_FUNCT;
         BRANCH:       alu_type = ALUOP_SUB;
         default:      alu_type = ALUOP_ADD;
      endcase
   end

   mc_alu_decoder u_alu_decoder (
      .alu_type    (alu_type),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .op5         (op[5]),
      .alu_control (alu_dec)
   );

   // Moore output table. The fetch strobes wait for the memory handshake and
   // the branch PC write waits for the compare; holding reset overrides all.
   always_comb begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      result_src  = RES_ALUOUT;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_REGB;
      alu_control = alu_dec;
      imm_src     = IMM_I;
      state_o     = state_q;

      if (op == OP_S)      imm_src = IMM_S;
      else if (op == OP_B) imm_src = IMM_B;
      else if (op == OP_J) imm_src = IMM_J;

      case (state_q)
         FETCH: begin
            mem_req    = 1'b1;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
         end
         DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
         end
         MEMADR: begin
            alu_src_a = SRCA_REGA;
            alu_src_b = SRCB_IMM;
         end
         MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
         end
         MEMWRITE: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            adr_src   = 1'b1;
         end
         EXECR: begin
            alu_src_a = SRCA_REGA;
            alu_src_b = SRCB_REGB;
         end
         EXECI: begin
            alu_src_a = SRCA_REGA;
            alu_src_b = SRCB_IMM;
         end
         ALUWB: begin
            result_src = RES_ALUOUT;
            reg_write  = 1'b1;
         end
         BRANCH: begin
            alu_src_a  = SRCA_REGA;
            alu_src_b  = SRCB_REGB;
            result_src = RES_ALUOUT;
            pc_write   = zero ^ funct3[0];
         end
         JAL: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALUOUT;
            pc_write   = 1'b1;
         end
         default: ;
      endcase

      if (!rst_n) begin
         mem_req     = 1'b0;
         mem_write   = 1'b0;
         adr_src     = 1'b0;
         ir_write    = 1'b0;
         pc_write    = 1'b0;
         reg_write   = 1'b0;
         result_src  = 2'd0;
         alu_src_a   = 2'd0;
         alu_src_b   = 2'd0;
         imm_src     = 2'd0;
         alu_control = 4'd0;
      end
   end

endmodule
